// File: rtl/decoder3to8_scan.sv
// Clocked 3-to-8 decoder with direct-load and round-robin scan modes.
// Registered one-hot select m, current code cur, valid and scan wrap pulse.
module decoder3to8_scan #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic       load,
  input  logic [2:0] s,
  output logic [7:0] m,
  output logic [2:0] cur,
  output logic       valid,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  state_e        state_q, state_d;
  logic [7:0]    m_q, m_d;
  logic [2:0]    cur_q, cur_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    nxt;

  assign nxt = cur_q + 3'd1;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    cur_d   = cur_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    if (!en) begin
      // cur keeps its last code so software can still read it
      state_d = IDLE;
      m_d     = 8'h00;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DIRECT: begin
          if (mode) begin
            state_d = SCAN;
            cur_d   = 3'd0;
            m_d     = 8'h01;
            valid_d = 1'b1;
            cnt_d   = '0;
          end else if (load) begin
            state_d = DIRECT;
            cur_d   = s;
            m_d     = 8'h01 << s;
            valid_d = 1'b1;
            if (state_q == IDLE) cnt_d = '0;
          end
        end
        SCAN: begin
          if (!mode) begin
            state_d = DIRECT;
            cnt_d   = '0;
            if (load) begin
              cur_d   = s;
              m_d     = 8'h01 << s;
              valid_d = 1'b1;
            end
          end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            cur_d  = nxt;
            m_d    = 8'h01 << nxt;
            wrap_d = (cur_q == 3'd7);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          m_d     = 8'h00;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= 8'h00;
      cur_q   <= 3'd0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m     = m_q;
  assign cur   = cur_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder3to8_scan.sv
// Directed bench for decoder3to8_scan: DWELL=4 and DWELL=1 instances,
// plus a behavioural 8-to-3 coder for loopback.
module tb_decoder3to8_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, mode = 1'b0, load = 1'b0;
  logic [2:0] s = 3'd0;
  logic [7:0] m;
  logic [2:0] cur;
  logic       valid, wrap;

  logic       en_b = 1'b0;
  logic [7:0] m_b;
  logic [2:0] cur_b;
  logic       valid_b, wrap_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder3to8_scan #(.DWELL(4), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .load(load), .s(s), .m(m), .cur(cur),
    .valid(valid), .wrap(wrap)
  );

  decoder3to8_scan #(.DWELL(1), .CW(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(1'b1),
    .load(1'b0), .s(3'd0), .m(m_b), .cur(cur_b),
    .valid(valid_b), .wrap(wrap_b)
  );

  function automatic logic [2:0] coder8to3(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 0; k < 8; k++) if (v[k]) r = 3'(k);
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] oh;
    int e;
    #12;
    check("rst_m", 32'(m), 32'h00);
    check("rst_cur", 32'(cur), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_m", 32'(m), 32'h00);

    // direct decode of all eight codes
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; s = 3'(i);
      tick();
      oh = 8'h01 << i;
      check("dir_m", 32'(m), 32'(oh));
      check("dir_cur", 32'(cur), 32'(i));
      check("dir_valid", 32'(valid), 32'd1);
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = 3'(i + 1);
      tick();
      check("dir_hold", 32'(m), 32'h80);
    end

    // scan DWELL=4 from DIRECT, one full period plus wrap
    mode = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      tick();
      e = (i / 4) % 8;
      oh = 8'h01 << e;
      check("scan_cur", 32'(cur), 32'(e));
      check("scan_m", 32'(m), 32'(oh));
      check("scan_wrap", 32'(wrap), (i == 32) ? 32'd1 : 32'd0);
      check("scan_valid", 32'(valid), 32'd1);
      if (valid) check("loopback", 32'(coder8to3(m)), 32'(cur));
    end
    tick();
    check("wrap_1cyc", 32'(wrap), 32'd0);
    for (int i = 0; i < 19; i++) tick();
    check("at5_cur", 32'(cur), 32'd5);

    // leave scan without load: freeze
    mode = 1'b0; load = 1'b0; s = 3'd7;
    tick();
    check("frz_m", 32'(m), 32'h20);
    check("frz_cur", 32'(cur), 32'd5);
    tick();
    check("frz_m2", 32'(m), 32'h20);
    load = 1'b1; s = 3'd2;
    tick();
    check("reload_m", 32'(m), 32'h04);
    load = 1'b0;

    // leave scan with load on the same edge
    mode = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("rescan_cur", 32'(cur), 32'd1);
    mode = 1'b0; load = 1'b1; s = 3'd6;
    tick();
    check("exit_ld_m", 32'(m), 32'h40);
    check("exit_ld_cur", 32'(cur), 32'd6);
    load = 1'b0;

    // enable drop at cur=3
    mode = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    check("en_at3", 32'(cur), 32'd3);
    en = 1'b0;
    tick();
    check("endrop_m", 32'(m), 32'h00);
    check("endrop_v", 32'(valid), 32'd0);
    check("endrop_cur", 32'(cur), 32'd3);
    en = 1'b1;
    tick();
    check("enre_m", 32'(m), 32'h01);
    check("enre_cur", 32'(cur), 32'd0);
    check("enre_v", 32'(valid), 32'd1);

    // async reset between edges mid-scan
    for (int i = 0; i < 9; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m", 32'(m), 32'h00);
    check("arst_cur", 32'(cur), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    // scan DWELL=1: advance every cycle, wrap every 8
    en_b = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      tick();
      check("d1_cur", 32'(cur_b), 32'(i % 8));
      check("d1_wrap", 32'(wrap_b),
            (i > 0 && i % 8 == 0) ? 32'd1 : 32'd0);
      oh = 8'h01 << (i % 8);
      check("d1_m", 32'(m_b), 32'(oh));
    end
    en_b = 1'b0;
    tick();
    check("d1_off", 32'(valid_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
